// File: rtl/rotator_pipe.sv
// -----------------------------------------------------------------------------
// rotator_pipe
//
// Pipelined barrel rotator/shifter. The operand passes through $clog2(WIDTH)
// layers. Layer k moves the data by 2^k bit positions when amt bit k is set.
// Layers are applied MSB-first. They are split into PIPE_STAGES groups, and a
// register follows each group. The amount, mode and tag travel with the data.
//
// Modes: 2'b00 rotate left, 2'b01 rotate right,
//        2'b10 logical shift left, 2'b11 logical shift right (zero fill).
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   flush_i      (only with ROTATOR_PIPE_FLUSH_EN) drop every in-flight op
//   in_valid_i   operation offered
//   in_ready_o   operation accepted this cycle if in_valid_i is high
//   data_i       operand
//   amt_i        shift/rotate amount
//   mode_i       operation select (see above)
//   tag_i        sideband, returned unchanged with the result
//   out_valid_o  result valid (registered)
//   out_ready_i  downstream takes the result
//   data_o       result (registered)
//   tag_o        tag of the result (registered)
//
// Optional feature macro: ROTATOR_PIPE_FLUSH_EN adds flush_i.
// -----------------------------------------------------------------------------
module rotator_pipe #(
   parameter int WIDTH       = 64,
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
`ifdef ROTATOR_PIPE_FLUSH_EN
   input  logic                       flush_i,
`endif
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [WIDTH-1:0]           data_i,
   input  logic [$clog2(WIDTH)-1:0]   amt_i,
   input  logic [1:0]                 mode_i,
   input  logic [TAG_W-1:0]           tag_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [TAG_W-1:0]           tag_o
);

   localparam int L = $clog2(WIDTH);
   localparam int P = PIPE_STAGES;

   // Layers owned by stage s. Earlier stages absorb the remainder.
   function automatic int grp_size(input int s);
      return (L / P) + ((s < (L % P)) ? 1 : 0);
   endfunction

   // Highest layer index handled by stage s (layers run MSB-first).
   function automatic int grp_hi(input int s);
      int h;
      h = L - 1;
      for (int j = 0; j < s; j++) begin
         h = h - grp_size(j);
      end
      return h;
   endfunction

   // One network layer: move by 2^k positions according to the mode.
   // Right rotation is done natively here, not as a left rotation by WIDTH-amt.
   function automatic logic [WIDTH-1:0] layer_op(input logic [WIDTH-1:0] d,
                                                 input int k,
                                                 input logic [1:0] mode);
      int sh;
      logic [WIDTH-1:0] r;
      sh = 1 << k;
      case (mode)
         2'b00:   r = (d << sh) | (d >> (WIDTH - sh));
         2'b01:   r = (d >> sh) | (d << (WIDTH - sh));
         2'b10:   r = d << sh;
         2'b11:   r = d >> sh;
         default: r = d;
      endcase
      return r;
   endfunction

   // Apply layers hi down to lo, each only when its amount bit is set.
   function automatic logic [WIDTH-1:0] apply_group(input logic [WIDTH-1:0] d,
                                                    input logic [L-1:0] amt,
                                                    input logic [1:0] mode,
                                                    input int hi,
                                                    input int lo);
      logic [WIDTH-1:0] r;
      r = d;
      for (int k = hi; k >= lo; k--) begin
         r = amt[k] ? layer_op(r, k, mode) : r;
      end
      return r;
   endfunction

   logic [P-1:0]     w_valid;
   logic [P-1:0]     w_adv;
   logic [WIDTH-1:0] w_data [P];
   logic [TAG_W-1:0] w_tag  [P];
   // w_amt[s] / w_mode[s] are the control inputs seen by stage s.
   logic [L-1:0]     w_amt  [P];
   logic [1:0]       w_mode [P];
   logic             w_flush;

`ifdef ROTATOR_PIPE_FLUSH_EN
   assign w_flush = flush_i;
`else
   assign w_flush = 1'b0;
`endif

   assign w_amt[0]  = amt_i;
   assign w_mode[0] = mode_i;

   // Advance chain: a stage moves when it is empty or its successor moves.
   // An empty stage therefore always fills, so bubbles collapse under a stall.
   always_comb begin
      w_adv        = '0;
      w_adv[P-1]   = ~w_valid[P-1] | out_ready_i;
      for (int s = P - 2; s >= 0; s--) begin
         w_adv[s] = ~w_valid[s] | w_adv[s+1];
      end
   end

   assign in_ready_o = w_adv[0] & ~w_flush;

   genvar g;
   for (g = 0; g < P; g++) begin : g_stage
      localparam int HI = grp_hi(g);
      localparam int LO = HI - grp_size(g) + 1;

      logic             w_vin;
      logic [WIDTH-1:0] w_din;
      logic [TAG_W-1:0] w_tin;
      logic [WIDTH-1:0] w_dout;
      logic             r_valid;
      logic [WIDTH-1:0] r_data;
      logic [TAG_W-1:0] r_tag;

      if (g == 0) begin : g_src_in
         assign w_vin = in_valid_i;
         assign w_din = data_i;
         assign w_tin = tag_i;
      end else begin : g_src_prev
         assign w_vin = w_valid[g-1];
         assign w_din = w_data[g-1];
         assign w_tin = w_tag[g-1];
      end

      assign w_dout = apply_group(w_din, w_amt[g], w_mode[g], HI, LO);

      // Stage register: valid follows the advance chain; payload loads only with a real op.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_tag   <= '0;
         end else if (w_flush) begin
            r_valid <= 1'b0;
         end else if (w_adv[g]) begin
            r_valid <= w_vin;
            if (w_vin) begin
               r_data <= w_dout;
               r_tag  <= w_tin;
            end
         end
      end

      assign w_valid[g] = r_valid;
      assign w_data[g]  = r_data;
      assign w_tag[g]   = r_tag;

      // Amount and mode are needed only by the stages that follow.
      if (g < P - 1) begin : g_ctl
         logic [L-1:0] r_amt;
         logic [1:0]   r_mode;

         // Carry the control fields alongside the partially processed data.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_amt  <= '0;
               r_mode <= 2'b00;
            end else if (w_adv[g] && w_vin && !w_flush) begin
               r_amt  <= w_amt[g];
               r_mode <= w_mode[g];
            end
         end

         assign w_amt[g+1]  = r_amt;
         assign w_mode[g+1] = r_mode;
      end
   end

   assign out_valid_o = w_valid[P-1];
   assign data_o      = w_data[P-1];
   assign tag_o       = w_tag[P-1];

endmodule

// File: tb/tb_rotator_pipe.sv
module tb_rotator_pipe;

   localparam int W = 64;
   localparam int P = 2;
   localparam int T = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  din = '0;
   logic [5:0]    amt = '0;
   logic [1:0]    mode = '0;
   logic [T-1:0]  tag_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  dout;
   logic [T-1:0]  tag_out;

   always #5 clk = ~clk;

   rotator_pipe #(.WIDTH(W), .PIPE_STAGES(P), .TAG_W(T)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .data_i(din), .amt_i(amt), .mode_i(mode), .tag_i(tag_in),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .data_o(dout), .tag_o(tag_out)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pops = 0;
   int first_pop = -1;
   int last_pop = -1;
   int stalls = 0;

   typedef struct {
      logic [W-1:0] d;
      logic [T-1:0] t;
   } exp_t;
   exp_t q[$];

   // Reference: rotation taken from a doubled word, shifts straight from SV operators.
   function automatic logic [W-1:0] model(input logic [W-1:0] d, input int a,
                                          input logic [1:0] m);
      logic [2*W-1:0] dd;
      logic [2*W-1:0] t;
      dd = {d, d};
      case (m)
         2'b00: begin t = dd << a; return t[2*W-1:W]; end
         2'b01: begin t = dd >> a; return t[W-1:0]; end
         2'b10: return d << a;
         default: return d >> a;
      endcase
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compare process: scoreboard of accepted ops, checked at every output transfer.
   initial begin
      logic         prev_hold;
      logic [W-1:0] prev_d;
      logic [T-1:0] prev_t;
      exp_t         e;
      prev_hold = 1'b0;
      prev_d = '0;
      prev_t = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            q.delete();
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               chk("hold_valid", {63'd0, out_valid}, 64'd1);
               chk("hold_data", dout, prev_d);
               chk("hold_tag", {60'd0, tag_out}, {60'd0, prev_t});
            end
            if (in_valid && in_ready) begin
               e.d = model(din, int'(amt), mode);
               e.t = tag_in;
               q.push_back(e);
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got %h expected no result", dout);
               end else begin
                  e = q.pop_front();
                  chk("stream_data", dout, e.d);
                  chk("stream_tag", {60'd0, tag_out}, {60'd0, e.t});
                  pops++;
                  if (first_pop < 0) first_pop = cyc;
                  last_pop = cyc;
               end
            end
            prev_hold = out_valid && !out_ready;
            prev_d = dout;
            prev_t = tag_out;
         end
      end
   end

   // Offer one op (called just after a rising edge); returns just after its accepting edge.
   task automatic drive(input logic [W-1:0] d, input logic [5:0] a,
                        input logic [1:0] m, input logic [T-1:0] t);
      int n;
      din = d; amt = a; mode = m; tag_in = t;
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
            break;
         end
      end
      stalls += n;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d pending expected 0", name, q.size());
      end
   endtask

   localparam logic [W-1:0] OP = 64'h0123456789ABCDEF;
   logic [W-1:0] dir_d   [8];
   logic [5:0]   dir_a   [8];
   logic [1:0]   dir_m   [8];
   logic [W-1:0] dir_exp [8];

   initial begin
      int pops0;
      logic [W-1:0] exp_a;

      dir_d = '{OP, OP, OP, OP, OP, OP, OP, OP};
      dir_a = '{6'd4, 6'd4, 6'd60, 6'd63, 6'd0, 6'd0, 6'd0, 6'd0};
      dir_m = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
      dir_exp = '{64'h123456789ABCDEF0, 64'hF0123456789ABCDE,
                  64'hF000000000000000, 64'h0000000000000000,
                  OP, OP, OP, OP};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_data", dout, 64'd0);
      chk("rst_tag", {60'd0, tag_out}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Pin the model against hand-computed values
      for (int i = 0; i < 8; i++) begin
         chk("model_pin", model(dir_d[i], int'(dir_a[i]), dir_m[i]), dir_exp[i]);
      end

      // Directed vectors with exact two-cycle latency
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         drive(dir_d[i], dir_a[i], dir_m[i], 4'(i + 5));
         @(negedge clk);
         chk("lat_early", {63'd0, out_valid}, 64'd0);
         @(negedge clk);
         chk("lat_valid", {63'd0, out_valid}, 64'd1);
         chk("dir_data", dout, dir_exp[i]);
         chk("dir_tag", {60'd0, tag_out}, {60'd0, 4'(i + 5)});
         @(posedge clk);
         #1;
      end

      // Back-to-back random stream, full throughput
      first_pop = -1;
      pops0 = pops;
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
         drive({$urandom, $urandom}, 6'($urandom_range(0, 63)),
               2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      end
      drain("stream");
      chk("stream_count", 64'(pops - pops0), 64'd100);
      chk("stream_span", 64'(last_pop - first_pop), 64'd99);
      chk("stream_stalls", 64'(stalls), 64'd0);
      @(posedge clk);
      #1;

      // Backpressure: two ops fill the pipe, third waits
      out_ready = 1'b0;
      pops0 = pops;
      exp_a = model(64'hA5A5_0000_FFFF_1234, 12, 2'b01);
      drive(64'hA5A5_0000_FFFF_1234, 6'd12, 2'b01, 4'hA);
      drive(64'h8000_0000_0000_0001, 6'd1, 2'b00, 4'hB);
      din = 64'h00FF_00FF_00FF_00FF; amt = 6'd8; mode = 2'b11; tag_in = 4'hC;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_data", dout, exp_a);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drive(64'h00FF_00FF_00FF_00FF, 6'd8, 2'b11, 4'hC);
      drain("bp");
      chk("bp_count", 64'(pops - pops0), 64'd3);
      @(posedge clk);
      #1;

      // Reset with two ops in flight
      pops0 = pops;
      drive(64'h1111_2222_3333_4444, 6'd3, 2'b00, 4'h1);
      drive(64'h5555_6666_7777_8888, 6'd5, 2'b10, 4'h2);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_data", dout, 64'd0);
      chk("mid_rst_tag", {60'd0, tag_out}, 64'd0);
      chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
      end
      chk("post_rst_pops", 64'(pops - pops0), 64'd0);
      @(posedge clk);
      #1;
      drive(OP, 6'd4, 2'b00, 4'h7);
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_op", dout, 64'h123456789ABCDEF0);
      drain("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1);
   end

endmodule
